// File: rtl/uart_tx_pacer_fifo_pkg.sv
// Shared UART frame constants and pacer types, used by uart_tx_pacer_fifo and uart_tx.
package uart_tx_pacer_fifo_pkg;

    localparam int   FRAME_BITS_DEF = 11;
    localparam logic START_BIT      = 1'b0;
    localparam logic STOP_BIT       = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } pacer_state_e;

    // Last count value of a pacing window of frame_bits bit periods; division truncates.
    function automatic int frame_cnt_max(input int clk_freq, input int uart_bps, input int frame_bits);
        return (clk_freq / uart_bps) * frame_bits - 1;
    endfunction

endpackage

// File: rtl/uart_tx_pacer_fifo_sync_fifo_byte.sv
// Byte-wide synchronous FIFO with registered full/empty/level; writes at full and reads at empty are ignored.
module sync_fifo_byte #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ZERO_L  = {(ADDR_W+1){1'b0}};

    logic [7:0]      r_mem [0:DEPTH-1];
    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic            r_full;
    logic            r_empty;
    logic [ADDR_W:0] r_level;

    logic            w_push;
    logic            w_pop;
    logic [ADDR_W:0] w_wr_ptr_nxt;
    logic [ADDR_W:0] w_rd_ptr_nxt;
    logic [ADDR_W:0] w_level_nxt;

    // Flags are computed from the post-edge pointers so they are valid the cycle after the edge.
    always_comb begin
        w_push       = wr_en & ~r_full;
        w_pop        = rd_en & ~r_empty;
        w_wr_ptr_nxt = r_wr_ptr + {{ADDR_W{1'b0}}, w_push};
        w_rd_ptr_nxt = r_rd_ptr + {{ADDR_W{1'b0}}, w_pop};
        w_level_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
    end

    // Pointer and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= ZERO_L;
            r_rd_ptr <= ZERO_L;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_level  <= ZERO_L;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_full   <= (w_level_nxt == DEPTH_L);
            r_empty  <= (w_level_nxt == ZERO_L);
            r_level  <= w_level_nxt;
        end
    end

    // Storage array; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign rd_data = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign full    = r_full;
    assign empty   = r_empty;
    assign level   = r_level;

endmodule

// File: rtl/uart_tx_pacer_fifo.sv
// Buffers flash-read bytes and releases them to uart_tx no faster than one frame plus a guard bit apart.
module uart_tx_pacer_fifo
    import uart_tx_pacer_fifo_pkg::*;
#(
    parameter int UART_BPS   = 9600,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int ADDR_W     = 4,
    parameter int FRAME_BITS = FRAME_BITS_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [7:0]        pi_data,
    input  logic              pi_flag,
    output logic [7:0]        po_data,
    output logic              po_flag,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow
);

    localparam int             CNT_FRAME_MAX = frame_cnt_max(CLK_FREQ, UART_BPS, FRAME_BITS);
    localparam int             CNT_W         = $clog2(CNT_FRAME_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX_L   = CNT_W'(CNT_FRAME_MAX);
    localparam logic [CNT_W-1:0] CNT_ZERO_L  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE_L   = {{(CNT_W-1){1'b0}}, 1'b1};

    pacer_state_e     r_state;
    pacer_state_e     w_state_nxt;
    logic [CNT_W-1:0] r_cnt_frame;
    logic [7:0]       r_po_data;
    logic             r_po_flag;
    logic             r_overflow;

    logic             w_pop;
    logic [7:0]       w_rd_data;
    logic             w_full;
    logic             w_empty;
    logic [ADDR_W:0]  w_level;

    sync_fifo_byte #(
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .wr_en   (pi_flag),
        .wr_data (pi_data),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty),
        .level   (w_level)
    );

    // Pacer state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pacer next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt_frame == CNT_MAX_L) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pacer decode: pop only from IDLE, using the registered empty flag.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            ST_IDLE: w_pop = ~w_empty;
            ST_WAIT: w_pop = 1'b0;
            default: w_pop = 1'b0;
        endcase
    end

    // Frame counter, release strobe/data and sticky overflow.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_cnt_frame <= CNT_ZERO_L;
            r_po_data   <= 8'h00;
            r_po_flag   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_po_flag <= w_pop;
            if (w_pop) begin
                r_po_data <= w_rd_data;
            end
            if (pi_flag && w_full) begin
                r_overflow <= 1'b1;
            end
            if (r_state == ST_WAIT && r_cnt_frame != CNT_MAX_L) begin
                r_cnt_frame <= r_cnt_frame + CNT_ONE_L;
            end else begin
                r_cnt_frame <= CNT_ZERO_L;
            end
        end
    end

    assign po_data  = r_po_data;
    assign po_flag  = r_po_flag;
    assign full     = w_full;
    assign empty    = w_empty;
    assign level    = w_level;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_pacer_fifo.sv
// Self-checking bench for uart_tx_pacer_fifo with CLK_FREQ=1000, UART_BPS=100 (release period 111 cycles).
module tb_uart_tx_pacer_fifo;

    localparam int PERIOD = 111;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] pi_data = 8'h00;
    logic       pi_flag = 1'b0;
    logic [7:0] po_data;
    logic       po_flag;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_rel = -1;

    logic [7:0] sb [$];

    typedef struct {
        logic [7:0] data;
        logic [4:0] exp_level;
    } vec_t;
    vec_t tbl [4];

    uart_tx_pacer_fifo #(
        .UART_BPS   (100),
        .CLK_FREQ   (1000),
        .ADDR_W     (4),
        .FRAME_BITS (11)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .pi_data  (pi_data),
        .pi_flag  (pi_flag),
        .po_data  (po_data),
        .po_flag  (po_flag),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every release must match the oldest accepted byte.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            last_rel = -1;
        end else if (po_flag) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_release actual=%0h required=none", po_data);
            end else begin
                check("release_data", {24'h0, po_data}, {24'h0, sb.pop_front()});
            end
            if (last_rel >= 0) check("release_gap_min", (cyc - last_rel) >= PERIOD, 32'd1);
            last_rel = cyc;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input bit accept);
        pi_data = d;
        pi_flag = 1'b1;
        if (accept) sb.push_back(d);
        tick();
        pi_flag = 1'b0;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        sb.delete();
        tick();
        tick();
        sys_rst = 1'b0;
        tick();
    endtask

    task automatic wait_release(input int budget, input string name, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (po_flag) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            failures++;
            $display("FAIL %s actual=timeout required=release", name);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, sb.size(), 32'd0);
    endtask

    initial begin
        int t0;
        int t_prev;
        int t_rel;
        logic [4:0] exp_after [3];

        tbl[0] = '{8'h01, 5'd1};
        tbl[1] = '{8'h02, 5'd1};
        tbl[2] = '{8'h03, 5'd2};
        tbl[3] = '{8'h04, 5'd3};
        exp_after[0] = 5'd2;
        exp_after[1] = 5'd1;
        exp_after[2] = 5'd0;

        // Reset state
        tick();
        check("rst_po_flag", po_flag, 32'd0);
        check("rst_po_data", po_data, 32'd0);
        check("rst_empty", empty, 32'd1);
        check("rst_full", full, 32'd0);
        check("rst_level", level, 32'd0);
        check("rst_overflow", overflow, 32'd0);
        sys_rst = 1'b0;
        repeat (8) tick();

        // 1. Single byte: two-edge latency, one-cycle strobe
        push(8'hA5, 1'b1);
        check("t1_flag_n1", po_flag, 32'd0);
        check("t1_level_n1", level, 32'd1);
        tick();
        check("t1_flag_n2", po_flag, 32'd1);
        check("t1_data_n2", po_data, 32'hA5);
        tick();
        check("t1_flag_n3", po_flag, 32'd0);
        check("t1_empty", empty, 32'd1);
        check("t1_data_hold", po_data, 32'hA5);
        repeat (PERIOD) tick();

        // 2. Burst of 4: table-driven pushes, then exact release spacing
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(tbl[i].data, 1'b1);
            if (i == 0) t0 = cyc;
            check("t2_level_push", level, {27'h0, tbl[i].exp_level});
        end
        t_prev = t0 + 1;
        for (int i = 0; i < 3; i++) begin
            wait_release(PERIOD + 5, "t2_release_timeout", t_rel);
            if (t_rel >= 0) begin
                check("t2_gap", t_rel - t_prev, PERIOD);
                check("t2_level_rel", level, {27'h0, exp_after[i]});
                t_prev = t_rel;
            end
        end
        check("t2_empty", empty, 32'd1);
        repeat (PERIOD) tick();

        // 3. Overflow: 18 back-to-back writes, the last is dropped
        do_reset();
        for (int i = 0; i < 17; i++) push(8'h10 + 8'(i), 1'b1);
        check("t3_level_full", level, 32'd16);
        check("t3_full", full, 32'd1);
        check("t3_ovf_before", overflow, 32'd0);
        push(8'hEE, 1'b0);
        check("t3_ovf_after", overflow, 32'd1);
        check("t3_level_drop", level, 32'd16);
        wait_drain(17 * PERIOD + 200, "t3_drain");
        tick();
        check("t3_empty_end", empty, 32'd1);
        check("t3_ovf_sticky", overflow, 32'd1);
        repeat (PERIOD) tick();

        // 4. Write at full coincident with the IDLE pop is still dropped
        do_reset();
        for (int i = 0; i < 17; i++) push(8'h40 + 8'(i), 1'b1);
        check("t4_level_full", level, 32'd16);
        repeat (95) tick();
        check("t4_flag_before", po_flag, 32'd0);
        push(8'hEE, 1'b0);
        check("t4_pop_flag", po_flag, 32'd1);
        check("t4_overflow", overflow, 32'd1);
        check("t4_level", level, 32'd15);
        check("t4_full", full, 32'd0);
        wait_drain(16 * PERIOD + 200, "t4_drain");
        repeat (PERIOD) tick();

        // 5. Wrap-around: 40 paced bytes
        do_reset();
        for (int i = 0; i < 40; i++) begin
            push(8'($urandom_range(0, 255)), 1'b1);
            repeat (PERIOD - 1) tick();
        end
        wait_drain(300, "t5_drain");
        check("t5_overflow", overflow, 32'd0);
        check("t5_empty", empty, 32'd1);
        repeat (PERIOD) tick();

        // 6. Reset mid-WAIT with three bytes queued
        do_reset();
        for (int i = 0; i < 4; i++) push(8'h70 + 8'(i), 1'b1);
        repeat (48) tick();
        check("t6_level_pre", level, 32'd3);
        sys_rst = 1'b1;
        sb.delete();
        #1;
        check("t6_po_flag", po_flag, 32'd0);
        check("t6_po_data", po_data, 32'd0);
        check("t6_level", level, 32'd0);
        check("t6_empty", empty, 32'd1);
        check("t6_full", full, 32'd0);
        check("t6_overflow", overflow, 32'd0);
        tick();
        sys_rst = 1'b0;
        tick();
        push(8'h3C, 1'b1);
        check("t6_flag_n1", po_flag, 32'd0);
        tick();
        check("t6_flag_n2", po_flag, 32'd1);
        check("t6_data_n2", po_data, 32'h3C);
        repeat (PERIOD + 20) tick();
        check("t6_sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
